// File: rtl/motion_seq.sv
`timescale 1ns/1ps
// Two-motor stepper sequencer: optional 90/180-degree pivot followed by a straight run,
// paced by a programmable step divider, with abort and one-cycle completion pulse.
module motion_seq #(
    parameter int STEP_W       = 16,
    parameter int DIV_W        = 16,
    parameter int TURN90_STEPS = 256,
    parameter int HALF_STEP    = 0,
    parameter int HOLD         = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  speed_div,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] remaining,
    output logic [3:0]        left_out,
    output logic [3:0]        right_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN     = 2'd1,
        STRAIGHT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [2:0]        IDX_MASK   = (HALF_STEP != 0) ? 3'd7 : 3'd3;
    localparam logic [STEP_W-1:0] TURN_STEPS = STEP_W'(TURN90_STEPS);
    localparam logic [STEP_W-1:0] UTURN_STEPS = STEP_W'(2 * TURN90_STEPS);
    localparam logic [STEP_W-1:0] ONE_STEP   = STEP_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        op_q;
    logic [STEP_W-1:0] steps_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [STEP_W-1:0] rem_q;
    logic [2:0]        left_idx;
    logic [2:0]        right_idx;
    logic              aborted_q;
    logic              accept;
    logic              tick;
    logic              left_fwd;
    logic              right_fwd;

    function automatic logic [3:0] coil(input logic [2:0] idx);
        logic [3:0] pat;
        if (HALF_STEP != 0) begin
            case (idx)
                3'd0:    pat = 4'b0001;
                3'd1:    pat = 4'b0011;
                3'd2:    pat = 4'b0010;
                3'd3:    pat = 4'b0110;
                3'd4:    pat = 4'b0100;
                3'd5:    pat = 4'b1100;
                3'd6:    pat = 4'b1000;
                default: pat = 4'b1001;
            endcase
        end else begin
            case (idx[1:0])
                2'd0:    pat = 4'b0001;
                2'd1:    pat = 4'b0010;
                2'd2:    pat = 4'b0100;
                default: pat = 4'b1000;
            endcase
        end
        return pat;
    endfunction

    function automatic logic [2:0] advance(input logic [2:0] idx, input logic fwd);
        return fwd ? ((idx + 3'd1) & IDX_MASK) : ((idx - 3'd1) & IDX_MASK);
    endfunction

    assign accept = (state == IDLE) && cmd_valid;

    // Abort wins over a pending tick, so the aborting cycle never moves the motors.
    assign tick = (div_cnt == div_q) && !abort &&
                  ((state == TURN) || ((state == STRAIGHT) && (rem_q != '0)));

    // Op 10 is the only left pivot; the straight run drives both motors forward.
    assign left_fwd  = (state == STRAIGHT) || (op_q != 2'b10);
    assign right_fwd = (state == STRAIGHT) || (op_q == 2'b10);

    // NOTE: every output of this block gets a default first so no path leaves state_nxt
    // unassigned; an unassigned path in always_comb would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = (cmd_op == 2'b00) ? STRAIGHT : TURN;
            end
            TURN: begin
                if (abort)                           state_nxt = DONE;
                else if (tick && rem_q == ONE_STEP)  state_nxt = STRAIGHT;
            end
            STRAIGHT: begin
                if (abort || rem_q == '0 || (tick && rem_q == ONE_STEP)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 2'b00;
            steps_q   <= '0;
            div_q     <= '0;
            div_cnt   <= '0;
            rem_q     <= '0;
            left_idx  <= 3'd0;
            right_idx <= 3'd0;
            aborted_q <= 1'b0;
        end else if (accept) begin
            op_q      <= cmd_op;
            steps_q   <= cmd_steps;
            div_q     <= speed_div;
            div_cnt   <= '0;
            aborted_q <= 1'b0;
            case (cmd_op)
                2'b00:   rem_q <= cmd_steps;
                2'b11:   rem_q <= UTURN_STEPS;
                default: rem_q <= TURN_STEPS;
            endcase
        end else begin
            if (state_nxt != state || tick) div_cnt <= '0;
            else if (busy)                  div_cnt <= div_cnt + 1'b1;

            if (tick) begin
                left_idx  <= advance(left_idx, left_fwd);
                right_idx <= advance(right_idx, right_fwd);
                rem_q     <= (state == TURN && rem_q == ONE_STEP) ? steps_q : rem_q - ONE_STEP;
            end

            if (busy && abort) aborted_q <= 1'b1;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == TURN) || (state == STRAIGHT);
    assign done      = (state == DONE);
    assign aborted   = (state == DONE) && aborted_q;
    assign remaining = rem_q;
    assign left_out  = (state == IDLE && HOLD == 0) ? 4'b0000 : coil(left_idx);
    assign right_out = (state == IDLE && HOLD == 0) ? 4'b0000 : coil(right_idx);

endmodule
